// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS/CTRL bit positions and FSM state types shared by the UART core.
package uart_pkg;

  localparam logic [4:0] UART_DATA   = 5'h00;
  localparam logic [4:0] UART_STATUS = 5'h04;
  localparam logic [4:0] UART_DVSR   = 5'h08;
  localparam logic [4:0] UART_CTRL   = 5'h0C;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_FULL    = 2;
  localparam int ST_RX_EMPTY   = 3;
  localparam int ST_TX_BUSY    = 4;
  localparam int ST_OVERRUN    = 5;
  localparam int ST_FRAME_ERR  = 6;
  localparam int ST_PARITY_ERR = 7;

  localparam int CTRL_RX_IE      = 0;
  localparam int CTRL_TX_IE      = 1;
  localparam int CTRL_PARITY_ODD = 2;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous show-ahead FIFO; an extra pointer bit separates full from empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  // A pop frees the slot on a full FIFO, so a same-cycle push still lands.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: memory-mapped UART (baud tick, TX/RX FSMs, FIFOs, register file, irq).
// Define UART_PARITY_EN to insert/check a parity bit (even, or odd via CTRL[2]).
//
// state     | meaning
// TX_IDLE   | line high, waiting for a tick with TX FIFO data
// TX_START  | driving start bit (16 ticks)
// TX_DATA   | shifting data bits LSB first (16 ticks each)
// TX_PARITY | driving parity bit (parity builds only)
// TX_STOP   | driving stop bit (SB_TICK ticks)
// RX_IDLE   | waiting for a falling edge on the synchronised line
// RX_START  | 7 ticks, then confirm the line is still low
// RX_DATA   | sampling data bits every 16 ticks
// RX_PARITY | sampling parity bit (parity builds only)
// RX_STOP   | sampling stop bit, then push or flag error
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int DVSR_W   = 16,
  parameter int DVSR_RST = 324
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  cpu_address,
  input  logic [31:0] cpu_wdata,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] cpu_rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int TCW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE) + 1;
  localparam int NBW = $clog2(DBIT) + 1;
  localparam logic [TCW-1:0]    T_BIT   = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0]    T_STOP  = TCW'(SB_TICK - 1);
  localparam logic [TCW-1:0]    T_START = TCW'(7 - 1);
  localparam logic [TCW-1:0]    T_ONE   = TCW'(1);
  localparam logic [NBW-1:0]    N_LAST  = NBW'(DBIT - 1);
  localparam logic [NBW-1:0]    N_ONE   = NBW'(1);
  localparam logic [DVSR_W-1:0] D_ONE   = DVSR_W'(1);

  logic [DVSR_W-1:0] r_dvsr;
  logic [DVSR_W-1:0] r_baud_cnt;
  logic              r_rx_ie;
  logic              r_tx_ie;
  logic              r_par_odd;
  logic              r_ovr;
  logic              r_ferr;
  logic              r_perr;
  logic [31:0]       r_rdata;
  logic              r_irq;

  logic              w_tick;
  logic              w_wr_data;
  logic              w_wr_status;
  logic              w_wr_dvsr;
  logic              w_wr_ctrl;
  logic              w_rd_data;
  logic [31:0]       w_rdata_nx;
  logic [7:0]        w_status;
  logic              w_unused;

  logic [DBIT-1:0]   w_tx_rdata;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_tx_pop;
  logic [DBIT-1:0]   w_rx_rdata;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic              w_rx_push;

  assign w_wr_data   = write_enable && ({cpu_address[4:2], 2'b00} == UART_DATA);
  assign w_wr_status = write_enable && ({cpu_address[4:2], 2'b00} == UART_STATUS);
  assign w_wr_dvsr   = write_enable && ({cpu_address[4:2], 2'b00} == UART_DVSR);
  assign w_wr_ctrl   = write_enable && ({cpu_address[4:2], 2'b00} == UART_CTRL);
  assign w_rd_data   = read_enable  && ({cpu_address[4:2], 2'b00} == UART_DATA);
  assign w_unused    = ^{cpu_wdata, cpu_address[1:0]};

  // Baud enable: counter spans 0..DVSR, one-cycle tick on the terminal value.
  assign w_tick = (r_baud_cnt == r_dvsr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_baud_cnt <= '0;
    else if (w_wr_dvsr || w_tick) r_baud_cnt <= '0;
    else                         r_baud_cnt <= r_baud_cnt + D_ONE;
  end

  uart_fifo #(.WIDTH(DBIT), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (w_wr_data),
    .i_wdata (cpu_wdata[DBIT-1:0]),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_rdata),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  // ---------------- TX ----------------
  tx_state_e        r_tx_state, w_tx_state_nx;
  logic [TCW-1:0]   r_tx_cnt, w_tx_cnt_nx;
  logic [NBW-1:0]   r_tx_nbit, w_tx_nbit_nx;
  logic [DBIT-1:0]  r_tx_sh, w_tx_sh_nx;
  logic             r_tx, w_tx_nx;
  logic             r_tx_par, w_tx_par_nx;
  logic             w_tx_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_nbit  <= '0;
      r_tx_sh    <= '0;
      r_tx       <= 1'b1;
      r_tx_par   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_nbit  <= w_tx_nbit_nx;
      r_tx_sh    <= w_tx_sh_nx;
      r_tx       <= w_tx_nx;
      r_tx_par   <= w_tx_par_nx;
    end
  end

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt;
    w_tx_nbit_nx  = r_tx_nbit;
    w_tx_sh_nx    = r_tx_sh;
    w_tx_nx       = r_tx;
    w_tx_par_nx   = r_tx_par;
    w_tx_pop      = 1'b0;
    w_tx_load     = 1'b0;
    if (w_tick) begin
      case (r_tx_state)
        TX_IDLE: w_tx_load = !w_tx_empty;
        TX_START: begin
          if (r_tx_cnt == '0) begin
            w_tx_state_nx = TX_DATA;
            w_tx_cnt_nx   = T_BIT;
            w_tx_nbit_nx  = N_LAST;
            w_tx_nx       = r_tx_sh[0];
          end else w_tx_cnt_nx = r_tx_cnt - T_ONE;
        end
        TX_DATA: begin
          if (r_tx_cnt == '0) begin
            w_tx_cnt_nx = T_BIT;
            w_tx_sh_nx  = r_tx_sh >> 1;
            if (r_tx_nbit == '0) begin
              if (PAR_EN) begin
                w_tx_state_nx = TX_PARITY;
                w_tx_nx       = r_tx_par;
              end else begin
                w_tx_state_nx = TX_STOP;
                w_tx_cnt_nx   = T_STOP;
                w_tx_nx       = 1'b1;
              end
            end else begin
              w_tx_nbit_nx = r_tx_nbit - N_ONE;
              w_tx_nx      = r_tx_sh[1];
            end
          end else w_tx_cnt_nx = r_tx_cnt - T_ONE;
        end
        TX_PARITY: begin
          if (r_tx_cnt == '0) begin
            w_tx_state_nx = TX_STOP;
            w_tx_cnt_nx   = T_STOP;
            w_tx_nx       = 1'b1;
          end else w_tx_cnt_nx = r_tx_cnt - T_ONE;
        end
        TX_STOP: begin
          // Chain straight into the next start bit so queued bytes leave back-to-back.
          if (r_tx_cnt == '0) begin
            if (!w_tx_empty) w_tx_load = 1'b1;
            else             w_tx_state_nx = TX_IDLE;
          end else w_tx_cnt_nx = r_tx_cnt - T_ONE;
        end
        default: w_tx_state_nx = TX_IDLE;
      endcase
    end
    if (w_tx_load) begin
      w_tx_pop      = 1'b1;
      w_tx_state_nx = TX_START;
      w_tx_cnt_nx   = T_BIT;
      w_tx_sh_nx    = w_tx_rdata;
      w_tx_par_nx   = (^w_tx_rdata) ^ r_par_odd;
      w_tx_nx       = 1'b0;
    end
  end

  assign tx = r_tx;

  // ---------------- RX ----------------
  logic             r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_e        r_rx_state, w_rx_state_nx;
  logic [TCW-1:0]   r_rx_cnt, w_rx_cnt_nx;
  logic [NBW-1:0]   r_rx_nbit, w_rx_nbit_nx;
  logic [DBIT-1:0]  r_rx_sh, w_rx_sh_nx;
  logic             r_rx_par_bad, w_rx_par_bad_nx;
  logic             w_ferr_set;
  logic             w_perr_set;
  logic             w_ovr_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_nbit    <= '0;
      r_rx_sh      <= '0;
      r_rx_par_bad <= 1'b0;
    end else begin
      r_rx_s1      <= rx;
      r_rx_s2      <= r_rx_s1;
      r_rx_prev    <= r_rx_s2;
      r_rx_state   <= w_rx_state_nx;
      r_rx_cnt     <= w_rx_cnt_nx;
      r_rx_nbit    <= w_rx_nbit_nx;
      r_rx_sh      <= w_rx_sh_nx;
      r_rx_par_bad <= w_rx_par_bad_nx;
    end
  end

  always_comb begin
    w_rx_state_nx   = r_rx_state;
    w_rx_cnt_nx     = r_rx_cnt;
    w_rx_nbit_nx    = r_rx_nbit;
    w_rx_sh_nx      = r_rx_sh;
    w_rx_par_bad_nx = r_rx_par_bad;
    w_rx_push       = 1'b0;
    w_ferr_set      = 1'b0;
    w_perr_set      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_s2) begin
          w_rx_state_nx = RX_START;
          w_rx_cnt_nx   = T_START;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_rx_cnt == '0) begin
            if (r_rx_s2) w_rx_state_nx = RX_IDLE;
            else begin
              w_rx_state_nx = RX_DATA;
              w_rx_cnt_nx   = T_BIT;
              w_rx_nbit_nx  = N_LAST;
            end
          end else w_rx_cnt_nx = r_rx_cnt - T_ONE;
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_rx_cnt == '0) begin
            w_rx_sh_nx  = {r_rx_s2, r_rx_sh[DBIT-1:1]};
            w_rx_cnt_nx = T_BIT;
            if (r_rx_nbit == '0) w_rx_state_nx = PAR_EN ? RX_PARITY : RX_STOP;
            else                 w_rx_nbit_nx  = r_rx_nbit - N_ONE;
          end else w_rx_cnt_nx = r_rx_cnt - T_ONE;
        end
      end
      RX_PARITY: begin
        if (w_tick) begin
          if (r_rx_cnt == '0) begin
            w_rx_par_bad_nx = r_rx_s2 != ((^r_rx_sh) ^ r_par_odd);
            w_rx_state_nx   = RX_STOP;
            w_rx_cnt_nx     = T_BIT;
          end else w_rx_cnt_nx = r_rx_cnt - T_ONE;
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (r_rx_cnt == '0) begin
            w_rx_state_nx = RX_IDLE;
            if (!r_rx_s2)                    w_ferr_set = 1'b1;
            else if (PAR_EN && r_rx_par_bad) w_perr_set = 1'b1;
            else                             w_rx_push  = 1'b1;
          end else w_rx_cnt_nx = r_rx_cnt - T_ONE;
        end
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  uart_fifo #(.WIDTH(DBIT), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (w_rx_push),
    .i_wdata (r_rx_sh),
    .i_pop   (w_rd_data),
    .o_rdata (w_rx_rdata),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // A full FIFO only drops the byte when the CPU is not popping in the same cycle.
  assign w_ovr_set = w_rx_push && w_rx_full && !w_rd_data;

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dvsr    <= DVSR_W'(DVSR_RST);
      r_rx_ie   <= 1'b0;
      r_tx_ie   <= 1'b0;
      r_par_odd <= 1'b0;
      r_ovr     <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      r_rdata   <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr_dvsr) r_dvsr <= cpu_wdata[DVSR_W-1:0];
      if (w_wr_ctrl) begin
        r_rx_ie   <= cpu_wdata[CTRL_RX_IE];
        r_tx_ie   <= cpu_wdata[CTRL_TX_IE];
        r_par_odd <= PAR_EN & cpu_wdata[CTRL_PARITY_ODD];
      end
      r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_wr_status & cpu_wdata[ST_OVERRUN]));
      r_ferr <= w_ferr_set | (r_ferr & ~(w_wr_status & cpu_wdata[ST_FRAME_ERR]));
      r_perr <= w_perr_set | (r_perr & ~(w_wr_status & cpu_wdata[ST_PARITY_ERR]));
      if (read_enable) r_rdata <= w_rdata_nx;
      r_irq <= (r_rx_ie & ~w_rx_empty) | (r_tx_ie & w_tx_empty);
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[ST_TX_FULL]    = w_tx_full;
    w_status[ST_TX_EMPTY]   = w_tx_empty;
    w_status[ST_RX_FULL]    = w_rx_full;
    w_status[ST_RX_EMPTY]   = w_rx_empty;
    w_status[ST_TX_BUSY]    = (r_tx_state != TX_IDLE);
    w_status[ST_OVERRUN]    = r_ovr;
    w_status[ST_FRAME_ERR]  = r_ferr;
    w_status[ST_PARITY_ERR] = r_perr;
  end

  always_comb begin
    w_rdata_nx = '0;
    case ({cpu_address[4:2], 2'b00})
      UART_DATA: begin
        w_rdata_nx[31] = w_rx_empty;
        if (!w_rx_empty) w_rdata_nx[DBIT-1:0] = w_rx_rdata;
      end
      UART_STATUS: w_rdata_nx[7:0]        = w_status;
      UART_DVSR:   w_rdata_nx[DVSR_W-1:0] = r_dvsr;
      UART_CTRL:   w_rdata_nx[2:0]        = {r_par_odd, r_tx_ie, r_rx_ie};
      default:     w_rdata_nx = '0;
    endcase
  end

  assign cpu_rdata = r_rdata;
  assign irq       = r_irq;

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: directed and randomised checks of uart_fifo_core against a frame-level model.
`timescale 1ns/1ps
module tb_uart_fifo_core;
  import uart_pkg::*;

  localparam int DBIT   = 8;
  localparam int DVSR   = 3;
  localparam int BITCYC = 16 * (DVSR + 1);
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FBITS = 1 + DBIT + PAR + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  cpu_address = '0;
  logic [31:0] cpu_wdata = '0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [31:0] cpu_rdata;
  logic        rx;
  logic        tx;
  logic        irq;
  logic        loop_en = 1'b0;
  logic        rx_drv = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  assign rx = loop_en ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_fifo_core #(
    .DBIT(DBIT), .SB_TICK(16), .TX_DEPTH(16), .RX_DEPTH(16), .DVSR_W(16), .DVSR_RST(324)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .write_enable(write_enable), .read_enable(read_enable), .cpu_rdata(cpu_rdata),
    .rx(rx), .tx(tx), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    cpu_address = addr; cpu_wdata = data; write_enable = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
    @(negedge clk);
    cpu_address = addr; read_enable = 1'b1;
    @(posedge clk); #1;
    data = cpu_rdata;
    read_enable = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(tag, d, exp);
  endtask

  // Expected line levels of one frame, bit k at index k.
  function automatic logic [31:0] frame_exp(input logic [7:0] b, input logic odd);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < DBIT; i++) v[1+i] = b[i];
    if (PAR == 1) v[1+DBIT] = (^b) ^ odd;
    v[FBITS-1] = 1'b1;
    return v;
  endfunction

  task automatic rx_send(input logic [7:0] b, input logic stop_lvl, input logic par_flip, input logic odd);
    logic [31:0] v;
    v = frame_exp(b, odd);
    if (PAR == 1) v[1+DBIT] = v[1+DBIT] ^ par_flip;
    v[FBITS-1] = stop_lvl;
    for (int k = 0; k < FBITS; k++) begin
      rx_drv = v[k];
      repeat (BITCYC) @(posedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_tx_low(input int limit, output int cyc);
    cyc = 0;
    while (tx !== 1'b0 && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Called 1 time unit after the edge that launched the start bit; samples mid-bit.
  task automatic capture(input int nbits, output logic [63:0] v);
    v = '0;
    repeat (BITCYC / 2) @(posedge clk);
    #1 v[0] = tx;
    for (int k = 1; k < nbits; k++) begin
      repeat (BITCYC) @(posedge clk);
      #1 v[k] = tx;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [63:0] v;
    logic [7:0]  q [$];
    logic [7:0]  b;
    int          cyc;
    int          guard;

    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_irq", {31'b0, irq}, 32'd0);
    check("reset_rdata", cpu_rdata, 32'd0);
    rd_check("reset_status", UART_STATUS, 32'h0000_000A);
    rd_check("reset_dvsr", UART_DVSR, 32'd324);
    rd_check("reset_ctrl", UART_CTRL, 32'd0);

    // Two back-to-back TX frames
    bus_write(UART_DVSR, DVSR);
    rd_check("dvsr_rw", UART_DVSR, DVSR);
    bus_write(UART_DATA, 32'h55);
    bus_write(UART_DATA, 32'hA3);
    wait_tx_low(40, cyc);
    check("tx_start_latency", {31'b0, (tx === 1'b0) && (cyc + 1 <= DVSR + 1)}, 32'd1);
    capture(2 * FBITS, v);
    check("tx_frame0", 32'(v[0 +: FBITS]), frame_exp(8'h55, 1'b0));
    check("tx_frame1", 32'(v[FBITS +: FBITS]), frame_exp(8'hA3, 1'b0));
    repeat (BITCYC) @(posedge clk);
    rd_check("tx_done_status", UART_STATUS, 32'h0000_000A);

    // Loopback with 17 random bytes into a 16-deep RX FIFO
    loop_en = 1'b1;
    for (int i = 0; i < 17; i++) q.push_back(8'($urandom_range(0, 255)));
    bus_write(UART_DATA, {24'b0, q[0]});
    repeat (10) @(posedge clk);
    for (int i = 1; i < 17; i++) bus_write(UART_DATA, {24'b0, q[i]});
    guard = 0;
    do begin
      repeat (64) @(posedge clk);
      bus_read(UART_STATUS, d);
      guard++;
    end while ((d[ST_TX_EMPTY] !== 1'b1 || d[ST_TX_BUSY] !== 1'b0) && guard < 400);
    check("loop_drain_in_time", {31'b0, guard < 400}, 32'd1);
    repeat (100) @(posedge clk);
    rd_check("loop_status_overrun", UART_STATUS, 32'h0000_0026);
    for (int i = 0; i < 16; i++) rd_check($sformatf("loop_byte%0d", i), UART_DATA, {24'b0, q[i]});
    rd_check("loop_empty_read", UART_DATA, 32'h8000_0000);
    bus_write(UART_STATUS, 32'h20);
    rd_check("overrun_w1c", UART_STATUS, 32'h0000_000A);
    loop_en = 1'b0;
    repeat (20) @(posedge clk);

    // Driven frames: good byte, bad stop bit, start glitch
    b = 8'($urandom_range(0, 255));
    rx_send(b, 1'b1, 1'b0, 1'b0);
    repeat (100) @(posedge clk);
    rd_check("rx_rand_byte", UART_DATA, {24'b0, b});
    rx_send(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    repeat (100) @(posedge clk);
    rd_check("frame_err_status", UART_STATUS, 32'h0000_004A);
    bus_write(UART_STATUS, 32'h40);
    rd_check("frame_err_w1c", UART_STATUS, 32'h0000_000A);
    rx_drv = 1'b0;
    repeat (2 * (DVSR + 1)) @(posedge clk);
    rx_drv = 1'b1;
    repeat (BITCYC * FBITS) @(posedge clk);
    rd_check("glitch_status", UART_STATUS, 32'h0000_000A);

    // Interrupts
    bus_write(UART_CTRL, 32'h1);
    rd_check("ctrl_rw", UART_CTRL, 32'h1);
    check("irq_rx_idle", {31'b0, irq}, 32'd0);
    rx_send(8'h3C, 1'b1, 1'b0, 1'b0);
    repeat (100) @(posedge clk);
    check("irq_rx_set", {31'b0, irq}, 32'd1);
    bus_read(UART_DATA, d);
    check("irq_rx_data", d, 32'h3C);
    check("irq_still_high", {31'b0, irq}, 32'd1);
    @(posedge clk); #1;
    check("irq_rx_fall", {31'b0, irq}, 32'd0);
    bus_write(UART_CTRL, 32'h2);
    repeat (2) @(posedge clk); #1;
    check("irq_tx_empty", {31'b0, irq}, 32'd1);
    bus_write(UART_CTRL, 32'h0);
    repeat (2) @(posedge clk); #1;
    check("irq_off", {31'b0, irq}, 32'd0);

`ifdef UART_PARITY_EN
    bus_write(UART_CTRL, 32'h4);
    rd_check("ctrl_parity_odd", UART_CTRL, 32'h4);
    bus_write(UART_DATA, 32'h07);
    wait_tx_low(40, cyc);
    capture(FBITS, v);
    check("tx_parity_bit", {31'b0, v[1+DBIT]}, 32'd0);
    check("tx_parity_frame", 32'(v[0 +: FBITS]), frame_exp(8'h07, 1'b1));
    repeat (BITCYC) @(posedge clk);
    rx_send(8'h07, 1'b1, 1'b1, 1'b1);
    repeat (100) @(posedge clk);
    rd_check("parity_err_status", UART_STATUS, 32'h0000_008A);
    rd_check("parity_err_dropped", UART_DATA, 32'h8000_0000);
    bus_write(UART_STATUS, 32'h80);
    bus_write(UART_CTRL, 32'h0);
`else
    bus_write(UART_CTRL, 32'h4);
    rd_check("ctrl_no_parity", UART_CTRL, 32'h0);
`endif

    // Reset in the middle of a transmitted frame
    bus_write(UART_DATA, 32'hF0);
    bus_write(UART_DATA, 32'h11);
    wait_tx_low(40, cyc);
    repeat (100) @(posedge clk);
    #1 reset_n = 1'b0;
    #2;
    check("midframe_reset_tx", {31'b0, tx}, 32'd1);
    @(negedge clk) reset_n = 1'b1;
    rd_check("post_reset_status", UART_STATUS, 32'h0000_000A);
    rd_check("post_reset_dvsr", UART_DVSR, 32'd324);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
